out_port_arb: RTL and testbench
===============================

OUT_PORT_ARB -- requirements
Module: out_port_arb

Interface
REQ-001 Parameter DATASIZE, default 30: flit width in bits; bit 0 is the multicast flag (1 = multicast).
REQ-002 Parameter NUM_IN, default 5: number of input-FIFO requesters; legal range 2..8.
REQ-003 Parameter PTRW, default 3: round-robin pointer width; SHALL be >= clog2(NUM_IN).
REQ-004 fifo_clk  input  1  sole clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  NUM_IN  per-requester input-FIFO non-empty flag.
REQ-007 in_data  input  NUM_IN*DATASIZE  per-requester head flit, packed; requester i occupies bits [i*DATASIZE +: DATASIZE]; show-ahead, so it is valid whenever in_valid[i]=1.
REQ-008 in_ready  output  NUM_IN  one-hot pop strobe to the input FIFOs; bit i drives that FIFO's read enable.
REQ-009 out_data  output  DATASIZE  registered flit to the downstream FIFO write data.
REQ-010 out_valid  output  1  registered write enable to the downstream FIFO.
REQ-011 out_full  input  1  downstream FIFO full flag.
REQ-012 flit_cnt  output  16  count of flits delivered downstream; saturates at 16'hFFFF.

Function
REQ-013 A transfer downstream SHALL occur in any cycle with out_valid=1 and out_full=0.
REQ-014 The output stage SHALL be a one-entry register with FSM states EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-015 The register SHALL be loadable in a cycle when it is EMPTY or when a transfer occurs (load_ok).
REQ-016 A grant SHALL occur only when load_ok=1 and at least one in_valid bit is 1.
REQ-017 On a grant, exactly one in_ready bit SHALL be high, combinationally in the same cycle; out_data SHALL capture that requester's in_data on the next edge.
REQ-018 in_ready SHALL be all-zero when no grant occurs, and SHALL never be asserted for a requester whose in_valid=0.
REQ-019 Arbitration SHALL be round-robin: search starts at rr_ptr and scans ascending with wrap NUM_IN-1 -> 0; the first valid requester wins.
REQ-020 After a grant to requester g, rr_ptr SHALL become (g+1) mod NUM_IN; without a grant rr_ptr SHALL hold.
REQ-021 EMPTY -> HOLD on a grant.
REQ-022 HOLD -> HOLD on a transfer with a simultaneous grant (back-to-back, 1 flit/cycle throughput).
REQ-023 HOLD -> EMPTY on a transfer with no grant.
REQ-024 HOLD with out_full=1 SHALL hold out_data and out_valid unchanged, with in_ready all-zero.
REQ-025 Latency from in_valid rising (register EMPTY) to out_valid=1 SHALL be exactly 1 cycle.
REQ-026 Flits SHALL pass unmodified, including the multicast bit; there is no priority by flit type.
REQ-027 flit_cnt SHALL increment by 1 on each transfer and saturate at 16'hFFFF.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, rr_ptr=0, flit_cnt=0, FSM=EMPTY; these take effect immediately, independent of the clock.
REQ-029 While rst_n=0, in_ready SHALL be all-zero.
REQ-030 Reset asserted in HOLD SHALL discard the held flit; no pop SHALL be issued during reset.
REQ-031 The first grant after deassertion SHALL go to the lowest-index valid requester.

Structure
REQ-032 The shared router package SHALL hold DATASIZE, the multicast bit index (0), and the FSM state encoding (EMPTY=0, HOLD=1).
REQ-033 The round-robin pick (request vector + pointer -> one-hot grant and index) SHALL be a sub-module named rr_pick, purely combinational; pointer and output registers stay in out_port_arb.

Verification
REQ-034 Reset: in_valid=5'b11111 held through reset -> in_ready=0, out_valid=0; after release, cycle 1 in_ready=5'b00001, cycle 2 out_data=in_data[0].
REQ-035 Fairness: all 5 valid, out_full=0 for 10 cycles -> grant order 0,1,2,3,4,0,1,2,3,4; out_valid continuously 1; flit_cnt=10 (or 9, depending on sample point).
REQ-036 Backpressure: HOLD with flit 30'h1234, out_full=1 for 4 cycles -> out_data stable, in_ready=0, flit_cnt unchanged; 1 cycle after out_full=0, flit_cnt increments by 1.
REQ-037 Wrap/skip: rr_ptr=4, in_valid=5'b00110 -> in_ready=5'b00010, then rr_ptr=2; next grant goes to requester 2.
REQ-038 Multicast passthrough: in_data[3]=30'h3FFF_FFFF (bit0=1) -> identical value on out_data.
REQ-039 Reset mid-HOLD: rst_n pulsed low while out_full=1 -> out_valid drops immediately; the held flit never appears and no pop is observed.
REQ-040 Saturation: flit_cnt forced to 16'hFFFE, then 3 transfers -> flit_cnt ends at 16'hFFFF.

Source files
------------

// File: rtl/out_port_arb_pkg.sv
// -----------------------------------------------------------------------------
// out_port_arb_pkg
// Shared router definitions: flit width, position of the multicast flag inside
// a flit, and the state encoding of the output-stage register.
// No ports (package).
// -----------------------------------------------------------------------------
package out_port_arb_pkg;

   localparam int DATASIZE  = 30;  // flit width in bits
   localparam int MCAST_BIT = 0;   // flit[MCAST_BIT] = 1 marks a multicast flit

   // Output register occupancy: EMPTY has nothing to offer downstream,
   // HOLD presents a flit with out_valid high.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } arb_state_e;

endpackage : out_port_arb_pkg

// File: rtl/out_port_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. Scans the request vector starting
// at ptr_i, ascending with wrap from NUM_IN-1 back to 0; the first set request
// wins.
//   req_i  : request vector, one bit per requester
//   ptr_i  : search start position (expected < NUM_IN)
//   gnt_o  : one-hot winner (all-zero when no request is set)
//   idx_o  : binary index of the winner (0 when no request is set)
//   any_o  : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_IN = 5,
   parameter int PTRW   = 3
) (
   input  logic [NUM_IN-1:0] req_i,
   input  logic [PTRW-1:0]   ptr_i,
   output logic [NUM_IN-1:0] gnt_o,
   output logic [PTRW-1:0]   idx_o,
   output logic              any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         int cand;
         // Position k steps after the pointer, folded back into 0..NUM_IN-1.
         cand = int'(ptr_i) + k;
         if (cand >= NUM_IN) cand = cand - NUM_IN;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = PTRW'(cand);
         end
      end
   end

endmodule : rr_pick

// File: rtl/out_port_arb.sv
// -----------------------------------------------------------------------------
// out_port_arb
// Output-port arbiter of a router: picks one of NUM_IN show-ahead input FIFOs
// round-robin and moves its head flit into a one-entry output register that
// feeds the downstream FIFO. Back-to-back transfers sustain one flit per cycle.
//   fifo_clk : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   in_valid : per-requester FIFO non-empty flags
//   in_data  : per-requester head flits, requester i at [i*DATASIZE +: DATASIZE]
//   in_ready : one-hot pop strobe, asserted in the grant cycle
//   out_data : registered flit towards the downstream FIFO
//   out_valid: registered write enable towards the downstream FIFO
//   out_full : downstream FIFO full
//   flit_cnt : number of flits delivered downstream, saturating
// -----------------------------------------------------------------------------
module out_port_arb #(
   parameter int DATASIZE = out_port_arb_pkg::DATASIZE,
   parameter int NUM_IN   = 5,
   parameter int PTRW     = 3
) (
   input  logic                       fifo_clk,
   input  logic                       rst_n,
   input  logic [NUM_IN-1:0]          in_valid,
   input  logic [NUM_IN*DATASIZE-1:0] in_data,
   output logic [NUM_IN-1:0]          in_ready,
   output logic [DATASIZE-1:0]        out_data,
   output logic                       out_valid,
   input  logic                       out_full,
   output logic [15:0]                flit_cnt
);

   import out_port_arb_pkg::*;

   arb_state_e            state_q, state_d;
   logic [DATASIZE-1:0]   out_data_q, out_data_d;
   logic [PTRW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [15:0]           flit_cnt_q, flit_cnt_d;

   logic                  xfer;
   logic                  load_ok;
   logic                  grant;
   logic [NUM_IN-1:0]     pick_gnt;
   logic [PTRW-1:0]       pick_idx;
   logic                  pick_any;
   logic [DATASIZE-1:0]   flit_arr [NUM_IN];
   logic [DATASIZE-1:0]   sel_flit;

   // Unpack the flat head-flit bus into one slice per requester.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign flit_arr[gi] = in_data[gi*DATASIZE +: DATASIZE];
   end

   rr_pick #(
      .NUM_IN (NUM_IN),
      .PTRW   (PTRW)
   ) u_rr_pick (
      .req_i  (in_valid),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   // One-hot AND-OR mux of the winning flit.
   always_comb begin
      sel_flit = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (pick_gnt[i]) sel_flit = sel_flit | flit_arr[i];
      end
   end

   // ---- FSM: state register --------------------------------------------------
   always_ff @(posedge fifo_clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   // ---- FSM: next state ------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (grant) state_d = ST_HOLD;
         ST_HOLD:  if (xfer)  state_d = grant ? ST_HOLD : ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // ---- FSM: outputs ---------------------------------------------------------
   // rst_n gates the grant because the asynchronously cleared state looks
   // loadable; no pop may escape while reset is held.
   always_comb begin
      out_valid = (state_q == ST_HOLD);
      xfer      = out_valid && !out_full;
      load_ok   = !out_valid || xfer;
      grant     = load_ok && pick_any && rst_n;
      in_ready  = grant ? pick_gnt : '0;
   end

   // ---- Datapath next state --------------------------------------------------
   always_comb begin
      out_data_d = out_data_q;
      rr_ptr_d   = rr_ptr_q;
      flit_cnt_d = flit_cnt_q;
      if (grant) begin
         out_data_d = sel_flit;
         rr_ptr_d   = (pick_idx == PTRW'(NUM_IN-1)) ? '0 : pick_idx + 1'b1;
      end
      if (xfer && (flit_cnt_q != 16'hFFFF)) flit_cnt_d = flit_cnt_q + 16'd1;
   end

   always_ff @(posedge fifo_clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q <= '0;
         rr_ptr_q   <= '0;
         flit_cnt_q <= '0;
      end else begin
         out_data_q <= out_data_d;
         rr_ptr_q   <= rr_ptr_d;
         flit_cnt_q <= flit_cnt_d;
      end
   end

   assign out_data = out_data_q;
   assign flit_cnt = flit_cnt_q;

endmodule : out_port_arb

// File: tb/tb_out_port_arb.sv
// -----------------------------------------------------------------------------
// tb_out_port_arb
// Self-checking bench for out_port_arb (5 requesters, 30-bit flits). A
// transaction-level reference model (occupancy flag, held flit, round-robin
// pointer, delivered count) predicts in_ready, out_valid, out_data and flit_cnt
// for every cycle; directed scenarios add explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_out_port_arb;

   localparam int N  = 5;
   localparam int DW = 30;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_full;
   logic [15:0]     flit_cnt;

   out_port_arb #(
      .DATASIZE (DW),
      .NUM_IN   (N),
      .PTRW     (3)
   ) dut (
      .fifo_clk  (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_full  (out_full),
      .flit_cnt  (flit_cnt)
   );

   always #5 clk = ~clk;

   int n_vec     = 0;
   int n_miscmp  = 0;

   // Reference model state.
   bit            m_hold;
   logic [DW-1:0] m_data;
   int            m_ptr;
   int            m_cnt;
   int            last_gnt;
   logic [DW-1:0] d_arr [N];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold   = 1'b0;
      m_data   = '0;
      m_ptr    = 0;
      m_cnt    = 0;
      last_gnt = -1;
   endtask

   // One clock cycle: drive inputs after the falling edge, compare the DUT with
   // the model's prediction, then advance the model across the coming edge.
   task automatic step(input logic [N-1:0] v, input logic f);
      int           g;
      bit           xfer;
      bit           ok;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      in_valid = v;
      out_full = f;
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = d_arr[i];
      #1;
      xfer = m_hold && !f;
      ok   = !m_hold || xfer;
      g    = -1;
      if (ok) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && v[c]) g = c;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
      check_val("out_valid", 64'(out_valid), 64'(m_hold));
      if (m_hold) check_val("out_data", 64'(out_data), 64'(m_data));
      check_val("flit_cnt", 64'(flit_cnt), 64'(m_cnt));
      $display("cyc valid=%b full=%b ready=%b ovalid=%b odata=%h cnt=%0d",
               v, f, in_ready, out_valid, out_data, flit_cnt);
      last_gnt = g;
      if (xfer && m_cnt < 65535) m_cnt++;
      if (g >= 0) begin
         m_hold = 1'b1;
         m_data = d_arr[g];
         m_ptr  = (g + 1) % N;
      end else if (xfer) begin
         m_hold = 1'b0;
      end
   endtask

   // Assert reset with all requesters valid, check that nothing is popped and
   // the outputs clear immediately, then release with inputs idle.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = '1;
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_data", 64'(out_data), 64'd0);
      check_val("rst_flit_cnt", 64'(flit_cnt), 64'd0);
      @(negedge clk);
      #1;
      check_val("rst_in_ready_hold", 64'(in_ready), 64'd0);
      check_val("rst_out_valid_hold", 64'(out_valid), 64'd0);
      in_valid = '0;
      rst_n    = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] cnt_before;
      rst_n    = 1'b0;
      in_valid = '0;
      in_data  = '0;
      out_full = 1'b0;
      for (int i = 0; i < N; i++) d_arr[i] = DW'(32'h0100_0000 * (i + 1) + 32'h11 * i);
      model_reset();

      // Reset with everyone valid, first grant to requester 0.
      do_reset();
      step(5'b11111, 1'b0);
      check_val("rst_first_gnt", 64'(in_ready), 64'b00001);
      step(5'b00000, 1'b1);
      check_val("rst_first_data", 64'(out_data), 64'(d_arr[0]));

      // Fairness: ten back-to-back grants from a fresh pointer.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(5'b11111, 1'b0);
         check_val("fair_order", 64'(last_gnt), 64'(i % N));
         if (i > 0) check_val("fair_ovalid", 64'(out_valid), 64'd1);
      end

      // Backpressure: hold 30'h1234 for four full cycles.
      d_arr[0] = 30'h1234;
      step(5'b11111, 1'b0);
      cnt_before = 16'(m_cnt);
      for (int i = 0; i < 4; i++) begin
         step(5'b11111, 1'b1);
         check_val("bp_data", 64'(out_data), 64'h1234);
         check_val("bp_ready", 64'(in_ready), 64'd0);
         check_val("bp_cnt", 64'(flit_cnt), 64'(cnt_before));
      end
      step(5'b11111, 1'b0);
      step(5'b00000, 1'b1);
      check_val("bp_cnt_inc", 64'(flit_cnt), 64'(cnt_before + 16'd1));

      // Wrap/skip: walk the pointer to 4, then requesters 1 and 2 only.
      do_reset();
      for (int i = 0; i < 4; i++) step(5'(1 << i), 1'b0);
      step(5'b00110, 1'b0);
      check_val("wrap_skip", 64'(in_ready), 64'b00010);
      step(5'b00110, 1'b0);
      check_val("wrap_next", 64'(in_ready), 64'b00100);

      // Multicast flit passes unmodified.
      d_arr[3] = 30'h3FFF_FFFF;
      step(5'b01000, 1'b0);
      step(5'b00000, 1'b1);
      check_val("mcast", 64'(out_data), 64'h3FFF_FFFF);

      // Reset while holding a blocked flit.
      d_arr[1] = 30'h2AAA_5555;
      step(5'b00010, 1'b1);
      step(5'b00010, 1'b1);
      do_reset();
      step(5'b00000, 1'b0);
      check_val("midhold_gone", 64'(out_valid), 64'd0);

      // Saturation of the delivered-flit counter.
      @(negedge clk);
      force dut.flit_cnt_q = 16'hFFFE;
      #1;
      release dut.flit_cnt_q;
      m_cnt = 16'hFFFE;
      for (int i = 0; i < 5; i++) step(5'b11111, 1'b0);
      check_val("sat", 64'(flit_cnt), 64'hFFFF);

      // Randomized traffic against the model.
      do_reset();
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < N; i++) d_arr[i] = DW'($urandom);
         step(N'($urandom), ($urandom % 4) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule : tb_out_port_arb
